mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, count width in bits, legal range 2..16.
REQ-002 SHALL provide parameter MODULUS, default 200, count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 SHALL provide parameter DIGITS, default 3, number of BCD digits; used only when MOD_COUNTER_BCD_EN is defined.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, count enable.
REQ-007 SHALL have port load, input, 1, synchronous parallel load request.
REQ-008 SHALL have port d, input, WIDTH, load value.
REQ-009 SHALL have port up, input, 1, direction (1 = increment, 0 = decrement).
REQ-010 SHALL have port mode, input, 1, end behaviour (0 = wrap, 1 = saturate).
REQ-011 SHALL have port count, output, WIDTH, registered count value.
REQ-012 SHALL have port tc, output, 1, registered terminal-count pulse.
REQ-013 SHALL have port load_err, output, 1, registered pulse flagging an out-of-range load.
REQ-014 SHALL have port bcd, output, 4*DIGITS, registered BCD image of count (MOD_COUNTER_BCD_EN only).

Function
REQ-015 Per-edge priority SHALL be: load, then en, then hold.
REQ-016 On load with d < MODULUS, count SHALL become d on the next edge and load_err SHALL be 0.
REQ-017 On load with d >= MODULUS, count SHALL become MODULUS-1 and load_err SHALL be 1 for exactly one cycle.
REQ-018 With en=1 and up=1, count SHALL advance by 1; at MODULUS-1 it SHALL go to 0 (mode=0) or stay at MODULUS-1 (mode=1).
REQ-019 With en=1 and up=0, count SHALL decrease by 1; at 0 it SHALL go to MODULUS-1 (mode=0) or stay at 0 (mode=1).
REQ-020 tc SHALL be 1 for exactly one cycle, on the edge where en=1, load=0 and count is at its terminal value for the current direction (MODULUS-1 up, 0 down), in both modes.
REQ-021 In saturate mode, tc SHALL re-pulse on every enabled edge at the terminal value.
REQ-022 Load SHALL suppress tc on that edge, even when en=1.
REQ-023 A change of up or mode SHALL take effect on the same edge, with no extra latency.
REQ-024 All arithmetic SHALL be unsigned WIDTH-bit; count SHALL never leave 0..MODULUS-1.

Reset
REQ-025 While reset=1, count SHALL be 0 and tc, load_err and bcd SHALL be 0, independent of clk.
REQ-026 After reset deasserts mid-operation, counting SHALL resume from 0 on the first edge with en=1.

Configuration
REQ-027 With macro MOD_COUNTER_BCD_EN defined, bcd SHALL equal the decimal digits of count, least-significant digit in bcd[3:0].
REQ-028 bcd SHALL lag count by exactly one clock.
REQ-029 If count exceeds 10**DIGITS-1, the upper digits SHALL be truncated.
REQ-030 Without MOD_COUNTER_BCD_EN, the bcd port and the BCD logic SHALL be absent.

Structure
REQ-031 Package mod_counter_pkg SHALL hold the mode encodings (MODE_WRAP, MODE_SAT) and the BCD digit width constant.
REQ-032 Binary-to-BCD conversion SHALL use a shift-add-3 sub-module, bin2bcd, instantiated only under MOD_COUNTER_BCD_EN.

Verification
REQ-033 Reset, then en=1, up=1, mode=0, 200 clocks -> count wraps 199->0 and tc pulses once at count=199.
REQ-034 Load d=5, then up=0, mode=1, 8 enabled clocks -> count 5..0, then holds at 0 with tc=1 on the last 3 edges.
REQ-035 Load d=250 with MODULUS=200 -> count=199, load_err=1 for one cycle.
REQ-036 load=1 and en=1 together at count=199, d=10 -> count=10 and tc=0.
REQ-037 Assert reset asynchronously between edges while count=57 -> count=0 immediately, no tc.
REQ-038 With MOD_COUNTER_BCD_EN, count=137 -> bcd=12'h137 one clock later.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants for mod_counter: end-behaviour encodings and BCD digit width.
// Build option MOD_COUNTER_BCD_EN adds a registered BCD image of the count.
package mod_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int unsigned BCD_DIGIT_W = 4;

endpackage

// File: rtl/bin2bcd.sv
// Combinational shift-add-3 binary-to-BCD converter; only built with MOD_COUNTER_BCD_EN.
// Only the low DIGITS digits are kept, so larger inputs come out modulo 10**DIGITS.
`ifdef MOD_COUNTER_BCD_EN
module bin2bcd
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic [WIDTH-1:0]              bin_i,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o
);

    localparam int unsigned AccW = BCD_DIGIT_W * DIGITS;

    logic [AccW-1:0] acc;

    // Carries only move upward, so dropping digits above DIGITS leaves the low digits exact.
    always_comb begin
        acc = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                if (acc[BCD_DIGIT_W*k +: BCD_DIGIT_W] >= 4'd5) begin
                    acc[BCD_DIGIT_W*k +: BCD_DIGIT_W] = acc[BCD_DIGIT_W*k +: BCD_DIGIT_W] + 4'd3;
                end
            end
            if (AccW > 1) begin
                acc = {acc[AccW-2:0], bin_i[i]};
            end else begin
                acc = bin_i[i];
            end
        end
        bcd_o = acc;
    end

endmodule
`endif

// File: rtl/mod_counter.sv
// Up/down modulo counter with wrap/saturate end behaviour, parallel load and tc pulse.
// Define MOD_COUNTER_BCD_EN to add the registered bcd output (lags count by one clock).
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 200,
    parameter int unsigned DIGITS  = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               load,
    input  logic [WIDTH-1:0]                   d,
    input  logic                               up,
    input  logic                               mode,
    output logic [WIDTH-1:0]                   count,
    output logic                               tc,
`ifdef MOD_COUNTER_BCD_EN
    output logic [BCD_DIGIT_W*DIGITS-1:0]      bcd,
`endif
    output logic                               load_err
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 2..16");
    end
    if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (DIGITS < 1) begin : g_bad_digits
        $error("mod_counter: DIGITS must be at least 1");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             load_err_q, load_err_d;
    logic             at_term;

    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        at_term    = up ? (count_q == MaxVal) : (count_q == '0);

        if (load) begin
            if ({1'b0, d} >= ModExt) begin
                count_d    = MaxVal;
                load_err_d = 1'b1;
            end else begin
                count_d = d;
            end
        end else if (en) begin
            tc_d = at_term;
            if (at_term) begin
                if (mode == MODE_SAT) begin
                    count_d = count_q;
                end else begin
                    count_d = up ? '0 : MaxVal;
                end
            end else begin
                count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

`ifdef MOD_COUNTER_BCD_EN
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_d, bcd_q;

    bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .bin_i (count_q),
        .bcd_o (bcd_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd = bcd_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter (default WIDTH=8, MODULUS=200, DIGITS=3).
// Build with MOD_COUNTER_BCD_EN defined to also check the bcd output.
`timescale 1ns/1ps
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d = '0;
    logic       up = 1'b1;
    logic       mode = 1'b0;
    logic [7:0] count;
    logic       tc;
    logic       load_err;
`ifdef MOD_COUNTER_BCD_EN
    logic [11:0] bcd;
`endif

    mod_counter #(
        .WIDTH   (8),
        .MODULUS (200),
        .DIGITS  (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .d        (d),
        .up       (up),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
`ifdef MOD_COUNTER_BCD_EN
        .bcd      (bcd),
`endif
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  cnt;
        logic        tc;
        logic        le;
        logic [11:0] bcd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_cnt = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; expectation describes outputs after the following rising edge.
    task automatic step(input logic rst_v, input logic en_v, input logic load_v,
                        input logic [7:0] d_v, input logic up_v, input logic mode_v,
                        input int exp_cnt, input logic exp_tc, input logic exp_le,
                        input string name);
        exp_t e;
        @(negedge clk);
        reset = rst_v;
        en    = en_v;
        load  = load_v;
        d     = d_v;
        up    = up_v;
        mode  = mode_v;
        e.name = name;
        e.cnt  = 8'(exp_cnt);
        e.tc   = exp_tc;
        e.le   = exp_le;
        e.bcd  = rst_v ? 12'h000 : to_bcd(last_cnt);
        sb_q.push_back(e);
        last_cnt = exp_cnt;
    endtask

    // Reset asserted between edges: outputs must clear without waiting for clk.
    task automatic async_reset();
        exp_t e;
        @(posedge clk);
        #2;
        en   = 1'b1;
        load = 1'b0;
        up   = 1'b1;
        #1;
        e.name = "async_reset";
        e.cnt  = 8'd0;
        e.tc   = 1'b0;
        e.le   = 1'b0;
        e.bcd  = 12'h000;
        sb_q.push_back(e);
        last_cnt = 0;
        reset = 1'b1;
    endtask

    // Monitor: every rising clock edge or reset assertion presents new outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.name, ".count"}, 32'(count), 32'(e.cnt));
                chk({e.name, ".tc"}, 32'(tc), 32'(e.tc));
                chk({e.name, ".load_err"}, 32'(load_err), 32'(e.le));
`ifdef MOD_COUNTER_BCD_EN
                chk({e.name, ".bcd"}, 32'(bcd), 32'(e.bcd));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion",
                 n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sd_cnt[8] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        logic       sd_tc[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Held in reset with en=1: nothing moves.
        step(1, 1, 0, 8'd0,   1, 0, 0,   0, 0, "rst_hold0");
        step(1, 1, 0, 8'd0,   1, 0, 0,   0, 0, "rst_hold1");
        step(0, 0, 0, 8'd0,   1, 0, 0,   0, 0, "rst_release");

        for (int i = 0; i < 200; i++) begin
            step(0, 1, 0, 8'd0, 1, 0, (i + 1) % 200, (i == 199), 0, "wrap_up");
        end

        step(0, 0, 1, 8'd5,   0, 1, 5,   0, 0, "load5");
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 8'd0, 0, 1, int'(sd_cnt[i]), sd_tc[i], 0, "sat_down");
        end
        step(0, 1, 0, 8'd0,   0, 0, 199, 1, 0, "wrap_down");

        step(0, 0, 1, 8'd250, 1, 0, 199, 0, 1, "load250");
        step(0, 0, 0, 8'd0,   1, 0, 199, 0, 0, "load_err_clear");
        step(0, 0, 1, 8'd200, 1, 0, 199, 0, 1, "load200");
        step(0, 0, 1, 8'd199, 1, 0, 199, 0, 0, "load199");
        step(0, 1, 1, 8'd10,  1, 0, 10,  0, 0, "load_over_en");

        step(0, 0, 1, 8'd198, 1, 1, 198, 0, 0, "load198");
        step(0, 1, 0, 8'd0,   1, 1, 199, 0, 0, "sat_up0");
        step(0, 1, 0, 8'd0,   1, 1, 199, 1, 0, "sat_up1");
        step(0, 1, 0, 8'd0,   1, 1, 199, 1, 0, "sat_up2");
        step(0, 1, 0, 8'd0,   0, 0, 198, 0, 0, "dir_change");

        step(0, 0, 1, 8'd137, 1, 0, 137, 0, 0, "load137");
        step(0, 0, 0, 8'd0,   1, 0, 137, 0, 0, "bcd137");

        step(0, 0, 1, 8'd57,  1, 0, 57,  0, 0, "load57");
        async_reset();
        step(1, 0, 0, 8'd0,   1, 0, 0,   0, 0, "rst_hold2");
        step(0, 1, 0, 8'd0,   1, 0, 1,   0, 0, "resume");
        step(0, 1, 0, 8'd0,   1, 0, 2,   0, 0, "resume2");

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
